// File: rtl/vowel_ram_ctrl_if.sv
// Character stream plus vowel RAM port bundle for vowel_ram_ctrl.
// slave: char_valid/char_in/char_last/ram_r_data in; char_ready/ram_addr/ram_w_en/ram_w_data out.
interface vowel_ram_ctrl_if;
    logic       char_valid;
    logic [7:0] char_in;
    logic       char_last;
    logic       char_ready;
    logic [5:0] ram_addr;
    logic       ram_w_en;
    logic [7:0] ram_w_data;
    logic [7:0] ram_r_data;

    modport master (
        output char_valid, char_in, char_last, ram_r_data,
        input  char_ready, ram_addr, ram_w_en, ram_w_data
    );

    modport slave (
        input  char_valid, char_in, char_last, ram_r_data,
        output char_ready, ram_addr, ram_w_en, ram_w_data
    );
endinterface

// File: rtl/vowel_ram_ctrl.sv
// Loads a password into a 64x8 RAM, then scans it back counting vowels.
// Ports: clock, reset_n (async low), bus (char stream + RAM), busy, done,
// length, vowel_count, overflow, pass (length/vowel/overflow criteria).
module vowel_ram_ctrl #(
    parameter int unsigned MIN_LEN    = 8,
    parameter int unsigned MIN_VOWELS = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    vowel_ram_ctrl_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic [6:0]        length,
    output logic [6:0]        vowel_count,
    output logic              overflow,
    output logic              pass
);

    localparam logic [6:0] MinLenW = 7'(MIN_LEN);
    localparam logic [6:0] MinVowW = 7'(MIN_VOWELS);
    localparam logic [6:0] Depth   = 7'd64;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCAN,
        DONE
    } state_e;

    state_e     state_q;
    logic [6:0] len_q;
    logic [6:0] vc_q;
    logic [6:0] vc_d;
    logic [5:0] scan_q;
    logic       ovf_q;
    logic       pass_q;
    logic       pass_d;
    logic       done_q;

    logic       xfer;
    logic       can_write;
    logic       is_vowel;
    logic       scan_last;
    logic [5:0] wr_addr;

    assign bus.char_ready = (state_q != SCAN);
    assign xfer           = bus.char_valid & bus.char_ready;

    // A new password always starts at address 0, even though length
    // still shows the previous result while sitting in DONE.
    always_comb begin
        wr_addr   = 6'd0;
        can_write = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                wr_addr   = 6'd0;
                can_write = 1'b1;
            end
            LOAD: begin
                wr_addr   = (len_q >= Depth) ? 6'd63 : len_q[5:0];
                can_write = (len_q < Depth);
            end
            default: begin
                wr_addr   = 6'd0;
                can_write = 1'b0;
            end
        endcase
    end

    // Write strobe follows the handshake combinationally; gated by
    // reset so nothing is written while the block is held.
    assign bus.ram_w_en   = reset_n & xfer & can_write;
    assign bus.ram_w_data = bus.ram_w_en ? bus.char_in : 8'h00;
    assign bus.ram_addr   = (state_q == SCAN) ? scan_q : wr_addr;

    always_comb begin
        unique case (bus.ram_r_data)
            8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
            8'h41, 8'h45, 8'h49, 8'h4F, 8'h55: is_vowel = 1'b1;
            default:                           is_vowel = 1'b0;
        endcase
    end

    // Termination compares the 6-bit address against the 7-bit length
    // so a full 64-entry scan ends without the address wrapping.
    assign scan_last = (({1'b0, scan_q} + 7'd1) == len_q);
    assign vc_d      = vc_q + {6'd0, is_vowel};
    assign pass_d    = (len_q >= MinLenW) && (vc_d >= MinVowW) && !ovf_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            len_q   <= 7'd0;
            vc_q    <= 7'd0;
            scan_q  <= 6'd0;
            ovf_q   <= 1'b0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (xfer) begin
                        len_q   <= 7'd1;
                        vc_q    <= 7'd0;
                        ovf_q   <= 1'b0;
                        pass_q  <= 1'b0;
                        scan_q  <= 6'd0;
                        state_q <= bus.char_last ? SCAN : LOAD;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        if (len_q < Depth) begin
                            len_q <= len_q + 7'd1;
                        end else begin
                            ovf_q <= 1'b1;
                        end
                        if (bus.char_last) begin
                            scan_q  <= 6'd0;
                            state_q <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    vc_q <= vc_d;
                    if (scan_last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= pass_d;
                    end else begin
                        scan_q <= scan_q + 6'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = (state_q == LOAD) || (state_q == SCAN);
    assign done        = done_q;
    assign length      = len_q;
    assign vowel_count = vc_q;
    assign overflow    = ovf_q;
    assign pass        = pass_q;

endmodule

// File: tb/tb_vowel_ram_ctrl.sv
// Randomized + directed bench for vowel_ram_ctrl with a RAM model
// and a string-level reference model of length/vowels/overflow/pass.
module tb_vowel_ram_ctrl;

    localparam int MIN_LEN    = 8;
    localparam int MIN_VOWELS = 2;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] length;
    logic [6:0] vowel_count;
    logic       overflow;
    logic       pass;

    vowel_ram_ctrl_if bus();

    vowel_ram_ctrl #(
        .MIN_LEN    (MIN_LEN),
        .MIN_VOWELS (MIN_VOWELS)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .length      (length),
        .vowel_count (vowel_count),
        .overflow    (overflow),
        .pass        (pass)
    );

    always #5 clock = ~clock;

    logic [7:0] mem [64];
    logic [5:0] wr_addr_q [$];
    logic [7:0] pw_q [$];
    int         checks      = 0;
    int         failures    = 0;
    int         done_pulses = 0;

    assign bus.ram_r_data = mem[bus.ram_addr];

    always @(posedge clock) begin
        if (bus.ram_w_en) begin
            mem[bus.ram_addr] <= bus.ram_w_data;
            wr_addr_q.push_back(bus.ram_addr);
        end
        if (done === 1'b1) done_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit is_vowel(input logic [7:0] c);
        return c inside {"a", "e", "i", "o", "u", "A", "E", "I", "O", "U"};
    endfunction

    task automatic set_pw(input string s);
        pw_q.delete();
        for (int i = 0; i < s.len(); i++) pw_q.push_back(s[i]);
    endtask

    task automatic set_rand_pw(input int n);
        string pool;
        pool = "aeiouAEIOUbxZ19 ";
        pw_q.delete();
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0)
                pw_q.push_back(8'($urandom_range(0, 255)));
            else
                pw_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
        end
    endtask

    task automatic drive_chars(input int gap, input string tag);
        int n;
        n = pw_q.size();
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap && i > 0; g++) begin
                @(negedge clock);
                bus.char_valid = 1'b0;
            end
            @(negedge clock);
            if (i == 1) begin
                chk({tag, ".first_len"}, 32'(length), 1);
                chk({tag, ".first_vc"}, 32'(vowel_count), 0);
                chk({tag, ".first_pass"}, 32'(pass), 0);
                chk({tag, ".first_busy"}, 32'(busy), 1);
            end
            bus.char_valid = 1'b1;
            bus.char_in    = pw_q[i];
            bus.char_last  = (i == n - 1);
            if (bus.char_ready !== 1'b1)
                chk({tag, ".ready_load"}, 32'(bus.char_ready), 1);
            @(posedge clock);
        end
    endtask

    task automatic run_pw(input int gap, input string tag);
        int n, exp_len, exp_vc, k, rdy_bad, bad;
        bit exp_ovf, exp_pass;
        n       = pw_q.size();
        exp_len = (n > 64) ? 64 : n;
        exp_vc  = 0;
        for (int i = 0; i < exp_len; i++) exp_vc += int'(is_vowel(pw_q[i]));
        exp_ovf  = (n > 64);
        exp_pass = (exp_len >= MIN_LEN) && (exp_vc >= MIN_VOWELS) && !exp_ovf;
        wr_addr_q.delete();
        drive_chars(gap, tag);
        // keep offering a character during SCAN; it must be refused
        @(negedge clock);
        bus.char_valid = 1'b1;
        bus.char_last  = 1'b0;
        bus.char_in    = "a";
        k       = 1;
        rdy_bad = 0;
        while (done !== 1'b1 && k < 200) begin
            if (bus.char_ready !== 1'b0) rdy_bad++;
            @(negedge clock);
            k++;
        end
        bus.char_valid = 1'b0;
        chk({tag, ".done_seen"}, 32'(k < 200), 1);
        chk({tag, ".scan_cycles"}, 32'(k), 32'(exp_len + 1));
        chk({tag, ".ready_scan"}, 32'(rdy_bad), 0);
        chk({tag, ".length"}, 32'(length), 32'(exp_len));
        chk({tag, ".vowels"}, 32'(vowel_count), 32'(exp_vc));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
        bad = 0;
        foreach (wr_addr_q[i]) if (int'(wr_addr_q[i]) != i) bad++;
        chk({tag, ".writes"}, 32'(wr_addr_q.size()), 32'(exp_len));
        chk({tag, ".addr_seq"}, 32'(bad), 0);
        @(negedge clock);
        chk({tag, ".done_pulse"}, 32'(done), 0);
        chk({tag, ".busy_done"}, 32'(busy), 0);
        chk({tag, ".len_hold"}, 32'(length), 32'(exp_len));
        chk({tag, ".pass_hold"}, 32'(pass), 32'(exp_pass));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".busy"}, 32'(busy), 0);
        chk({tag, ".done"}, 32'(done), 0);
        chk({tag, ".length"}, 32'(length), 0);
        chk({tag, ".vowels"}, 32'(vowel_count), 0);
        chk({tag, ".overflow"}, 32'(overflow), 0);
        chk({tag, ".pass"}, 32'(pass), 0);
        chk({tag, ".ready"}, 32'(bus.char_ready), 1);
        chk({tag, ".w_en"}, 32'(bus.ram_w_en), 0);
        chk({tag, ".addr"}, 32'(bus.ram_addr), 0);
        chk({tag, ".w_data"}, 32'(bus.ram_w_data), 0);
    endtask

    initial begin
        int snap;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        bus.char_valid = 1'b1;
        bus.char_in    = "a";
        bus.char_last  = 1'b0;
        repeat (2) @(negedge clock);
        #1 check_reset("rst0");
        bus.char_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b1;

        set_pw("Password1");
        run_pw(0, "pw1");
        set_pw("AbEcIdOx");
        run_pw(0, "abe");
        set_pw("xyz");
        run_pw(0, "xyz");
        set_pw("e");
        run_pw(0, "e1");
        pw_q.delete();
        for (int i = 0; i < 70; i++) pw_q.push_back("a");
        run_pw(0, "ovf70");
        set_pw("queue123");
        run_pw(0, "q_nogap");
        set_pw("queue123");
        run_pw(3, "q_gap3");

        set_rand_pw(20);
        drive_chars(0, "rst_mid");
        @(negedge clock);
        bus.char_valid = 1'b0;
        repeat (5) @(negedge clock);
        snap = done_pulses;
        #2 reset_n = 1'b0;
        bus.char_valid = 1'b1;
        bus.char_in    = "e";
        #1 check_reset("rst_scan");
        repeat (3) @(negedge clock);
        bus.char_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_scan.no_done", 32'(done_pulses), 32'(snap));
        @(posedge clock);
        #2 reset_n = 1'b1;
        set_pw("Password1");
        run_pw(0, "after_rst");

        for (int t = 0; t < 16; t++) begin
            set_rand_pw($urandom_range(1, 80));
            run_pw($urandom_range(0, 2), $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=1 exp=0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vowel_ram_ctrl.md
VOWEL_RAM_CTRL -- requirements
Module: vowel_ram_ctrl

Interface
REQ-001 The block SHALL have parameter MIN_LEN, default 8: minimum password length for pass.
REQ-002 The block SHALL have parameter MIN_VOWELS, default 2: minimum vowel count for pass.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 char_valid  in  1  password character offered this cycle.
REQ-006 char_in  in  8  ASCII character.
REQ-007 char_last  in  1  qualifies char_in as the final character; sampled only with char_valid.
REQ-008 char_ready  out  1  block accepts char_in this cycle; transfer = char_valid & char_ready.
REQ-009 ram_addr  out  6  address to the 64x8 vowel RAM.
REQ-010 ram_w_en  out  1  RAM write enable; RAM writes on posedge clock.
REQ-011 ram_w_data  out  8  RAM write data.
REQ-012 ram_r_data  in  8  RAM read data, combinational from ram_addr.
REQ-013 busy  out  1  high in LOAD or SCAN.
REQ-014 done  out  1  one-cycle pulse when results become valid.
REQ-015 length  out  7  accepted character count, 0..64.
REQ-016 vowel_count  out  7  vowels found, 0..64.
REQ-017 overflow  out  1  more than 64 characters were offered.
REQ-018 pass  out  1  length>=MIN_LEN & vowel_count>=MIN_VOWELS & !overflow.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, SCAN, DONE.
REQ-020 In IDLE and DONE, char_ready SHALL be 1; a transfer SHALL clear length, vowel_count, overflow and pass, write char_in to address 0, set length=1 and enter LOAD; if char_last is also set, the FSM SHALL enter SCAN instead.
REQ-021 In LOAD, char_ready SHALL be 1; each transfer with length<64 SHALL write char_in at address length (ram_w_en=1, ram_w_data=char_in) in the same cycle and increment length.
REQ-022 In LOAD, a transfer with length=64 SHALL NOT write the RAM. It SHALL set overflow, hold length at 64 and stay accepting until char_last.
REQ-023 A transfer with char_last SHALL move LOAD to SCAN on the next edge. That character SHALL still be written if length<64.
REQ-024 In SCAN, char_ready SHALL be 0 and ram_w_en SHALL be 0. ram_addr SHALL step from 0 to length-1, one address per cycle.
REQ-025 In SCAN, each cycle vowel_count SHALL increment when ram_r_data is one of a,e,i,o,u,A,E,I,O,U (0x61,0x65,0x69,0x6F,0x75,0x41,0x45,0x49,0x4F,0x55); all other bytes SHALL NOT count.
REQ-026 SCAN SHALL last exactly length cycles. On the edge after the last address, the FSM SHALL enter DONE, assert done for that one cycle and register pass.
REQ-027 Outside SCAN, ram_addr SHALL equal the current write address (length, saturated to 63), so that ram_w_en is never high with an undefined address.
REQ-028 length, vowel_count, overflow and pass SHALL hold their values in DONE until the next accepted character.
REQ-029 Counters SHALL be 7 bits and SHALL never wrap; the scan address counter SHALL be 6 bits, with termination compared against length.
REQ-030 char_valid=0 in LOAD SHALL stall with no state change; there is no timeout.

Reset
REQ-031 While reset_n=0, the block SHALL immediately force: state IDLE, char_ready=1, ram_w_en=0, ram_addr=0, ram_w_data=0, busy=0, done=0, length=0, vowel_count=0, overflow=0, pass=0.
REQ-032 Reset asserted mid-LOAD or mid-SCAN SHALL abort the operation. RAM contents are not cleared and SHALL NOT be relied on by the block.
REQ-033 After reset_n rises, the first posedge SHALL be able to accept a character.

Verification
REQ-034 "Password1" (9 chars, last on '1') -> 9 writes at addresses 0..8, SCAN 9 cycles, done pulse, length=9, vowel_count=2 (a,o), pass=1.
REQ-035 "AbEcIdOx" (8 chars) -> vowel_count=4, length=8, pass=1. Then "xyz" -> results clear on first char, length=3, vowel_count=0, pass=0.
REQ-036 Single char 'e' with char_valid and char_last in IDLE -> write addr 0, SCAN 1 cycle, length=1, vowel_count=1, pass=0.
REQ-037 70 chars all 'a', last on 70th -> exactly 64 writes, overflow=1, length=64, vowel_count=64, pass=0.
REQ-038 Reset pulsed during SCAN of a 20-char password -> all outputs at reset values immediately, no done pulse, next password processed correctly.
REQ-039 char_valid gaps of 3 idle cycles between characters of "queue123" -> identical results to gapless input: length=8, vowel_count=4, pass=1.
